// File: rtl/tx_buf_wr_arbiter.sv
// Round-robin, frame-at-a-time arbiter for the TX frame buffer write port; publishes the committed write pointer.
// Latency: grant 1 cycle after request, memory write 1 cycle after acceptance, commit 1 cycle after the final write.
// Backpressure: a picked channel that lacks buffer space holds the port idle; producer bubbles stall the frame.
module tx_buf_wr_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DEPTH      = 512,
    parameter int MAX_QWORDS = 200
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic [ADDR_W:0]   req0_qwords,
    input  logic [63:0]       wr0_data,
    input  logic              wr0_valid,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W:0]   req1_qwords,
    input  logic [63:0]       wr1_data,
    input  logic              wr1_valid,
    output logic              gnt1,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [63:0]       mem_wr_data,
    output logic [ADDR_W:0]   commited_wr_addr,
    input  logic [ADDR_W:0]   commited_rd_addr,
    output logic              err_badlen,
    output logic              busy
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] MAX_LEN = PW'(MAX_QWORDS);
    localparam logic [PW:0]   DEPTH_W = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] len;
    logic [PW-1:0] cnt;
    logic [PW-1:0] used;
    logic [PW:0]   free;
    logic          rr_pref;
    logic          owner;
    logic          len_ok0;
    logic          len_ok1;
    logic          cand0;
    logic          cand1;
    logic          fits0;
    logic          fits1;
    logic          pick;
    logic [PW-1:0] pick_len;
    logic          start;
    logic          own_valid;
    logic [63:0]   own_data;
    logic          accept;
    logic          last;

    // The wrap bit keeps used==DEPTH (full) distinct from used==0 (empty).
    always_comb begin
        used     = wr_ptr - commited_rd_addr;
        free     = DEPTH_W - {1'b0, used};
        len_ok0  = (req0_qwords != '0) && (req0_qwords <= MAX_LEN);
        len_ok1  = (req1_qwords != '0) && (req1_qwords <= MAX_LEN);
        fits0    = ({1'b0, req0_qwords} <= free);
        fits1    = ({1'b0, req1_qwords} <= free);
        cand0    = req0 && len_ok0;
        cand1    = req1 && len_ok1;
        // The preferred channel wins whenever it asks, even if it must wait for space.
        pick     = rr_pref ? cand1 : !cand0;
        pick_len = pick ? req1_qwords : req0_qwords;
        start    = (state == IDLE) && (pick ? (cand1 && fits1) : (cand0 && fits0));
        own_valid = owner ? wr1_valid : wr0_valid;
        own_data  = owner ? wr1_data : wr0_data;
        accept   = (state == XFER) && own_valid;
        last     = accept && (cnt == len - 1'b1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = XFER;
            XFER:    if (last) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr           <= '0;
            rr_pref          <= 1'b0;
            owner            <= 1'b0;
            len              <= '0;
            cnt              <= '0;
            gnt0             <= 1'b0;
            gnt1             <= 1'b0;
            mem_wr_en        <= 1'b0;
            mem_wr_addr      <= '0;
            mem_wr_data      <= '0;
            commited_wr_addr <= '0;
            err_badlen       <= 1'b0;
        end else begin
            mem_wr_en <= accept;
            if (start) begin
                owner <= pick;
                len   <= pick_len;
                cnt   <= '0;
                gnt0  <= !pick;
                gnt1  <= pick;
            end
            if (accept) begin
                mem_wr_addr <= wr_ptr[ADDR_W-1:0];
                mem_wr_data <= own_data;
                wr_ptr      <= wr_ptr + 1'b1;
                cnt         <= cnt + 1'b1;
            end
            if (last) begin
                gnt0    <= 1'b0;
                gnt1    <= 1'b0;
                rr_pref <= !owner;
            end
            // wr_ptr already includes the final qword written during this cycle.
            if (state == COMMIT) begin
                commited_wr_addr <= wr_ptr;
            end
            if ((req0 && !len_ok0) || (req1 && !len_ok1)) begin
                err_badlen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tx_buf_wr_arbiter.sv
// Randomized bench for tx_buf_wr_arbiter; a frame-level round-robin model predicts grants, writes and commits.
module tb_tx_buf_wr_arbiter;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req [2];
    logic [9:0]  qw  [2];
    logic [63:0] wd  [2];
    logic        wv  [2];
    logic        gnt0, gnt1, mem_wr_en, err_badlen, busy;
    logic [8:0]  mem_wr_addr;
    logic [63:0] mem_wr_data;
    logic [9:0]  commited_wr_addr;
    logic [9:0]  rd;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    bit drv_en;
    int flen [2][16];
    int fcnt [2];
    int fidx [2];
    int sent [2];
    bit active [2];
    bit offered [2];
    int req_cyc [2];

    logic [8:0]  m_addr[$];
    logic [63:0] m_data[$];
    int          m_wcyc[$];
    logic [9:0]  m_commit[$];
    int          m_gnt[$];
    int          m_gcyc[$];
    logic [9:0]  last_cm;
    logic        pg0, pg1;
    int          both_gnt;

    int          e_addr[$];
    logic [63:0] e_data[$];
    int          e_commit[$];
    int          e_gnt[$];
    int          e_fend[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tx_buf_wr_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req[0]), .req0_qwords(qw[0]), .wr0_data(wd[0]), .wr0_valid(wv[0]), .gnt0(gnt0),
        .req1(req[1]), .req1_qwords(qw[1]), .wr1_data(wd[1]), .wr1_valid(wv[1]), .gnt1(gnt1),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .commited_wr_addr(commited_wr_addr), .commited_rd_addr(rd),
        .err_badlen(err_badlen), .busy(busy)
    );

    function automatic logic [63:0] mk(input int c, input int f, input int i);
        return {24'hD0D0D0, 8'(c), 16'(f), 16'(i)};
    endfunction

    // Producers: each channel walks its frame list, with random bubbles and junk while not granted.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (drv_en) begin
                for (int c = 0; c < 2; c++) begin
                    logic g;
                    g = (c == 0) ? gnt0 : gnt1;
                    if (offered[c]) sent[c]++;
                    offered[c] = 1'b0;
                    wv[c] = 1'b0;
                    wd[c] = {$urandom, $urandom};
                    if (active[c]) begin
                        if (g && sent[c] < flen[c][fidx[c]]) begin
                            wv[c] = ($urandom_range(3) != 0);
                            wd[c] = mk(c, fidx[c], sent[c]);
                            offered[c] = wv[c];
                        end else if (!g && sent[c] == flen[c][fidx[c]]) begin
                            req[c] = 1'b0;
                            active[c] = 1'b0;
                            fidx[c]++;
                        end else if (!g) begin
                            wv[c] = ($urandom_range(1) != 0);
                        end
                    end
                    if (!active[c] && fidx[c] < fcnt[c]) begin
                        active[c] = 1'b1;
                        sent[c] = 0;
                        req[c] = 1'b1;
                        qw[c] = 10'(flen[c][fidx[c]]);
                        req_cyc[c] = cyc;
                    end
                end
            end
        end
    end

    initial begin
        last_cm = '0;
        pg0 = 1'b0;
        pg1 = 1'b0;
        both_gnt = 0;
        forever begin
            @(negedge clk);
            if (mem_wr_en) begin
                m_addr.push_back(mem_wr_addr);
                m_data.push_back(mem_wr_data);
                m_wcyc.push_back(cyc);
            end
            if (commited_wr_addr != last_cm) begin
                m_commit.push_back(commited_wr_addr);
                last_cm = commited_wr_addr;
            end
            if (gnt0 && !pg0) begin m_gnt.push_back(0); m_gcyc.push_back(cyc); end
            if (gnt1 && !pg1) begin m_gnt.push_back(1); m_gcyc.push_back(cyc); end
            if (gnt0 && gnt1) both_gnt++;
            pg0 = gnt0;
            pg1 = gnt1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: bench time limit reached");
        $fatal(1);
    end

    task automatic clear_mon();
        m_addr.delete(); m_data.delete(); m_wcyc.delete();
        m_commit.delete(); m_gnt.delete(); m_gcyc.delete();
        both_gnt = 0;
    endtask

    task automatic do_reset();
        drv_en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            req[c] = 1'b0; qw[c] = '0; wd[c] = '0; wv[c] = 1'b0;
            fcnt[c] = 0; fidx[c] = 0; sent[c] = 0; active[c] = 1'b0; offered[c] = 1'b0;
        end
        rd = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        clear_mon();
        drv_en = 1'b1;
    endtask

    // Frame-level model: preferred channel if it has frames pending, else the other; preference flips after each frame.
    task automatic build_expect(input int pref, input int ptr, input int n0, input int n1);
        int a[2];
        int n[2];
        int p;
        int c;
        a[0] = fidx[0]; a[1] = fidx[1];
        n[0] = n0; n[1] = n1;
        p = pref;
        e_addr.delete(); e_data.delete(); e_commit.delete(); e_gnt.delete(); e_fend.delete();
        while (a[0] < n[0] || a[1] < n[1]) begin
            c = (a[p] < n[p]) ? p : 1 - p;
            for (int i = 0; i < flen[c][a[c]]; i++) begin
                e_addr.push_back(ptr % DEPTH);
                e_data.push_back(mk(c, a[c], i));
                ptr = (ptr + 1) % 1024;
            end
            e_fend.push_back(e_addr.size() - 1);
            e_commit.push_back(ptr);
            e_gnt.push_back(c);
            a[c]++;
            p = 1 - c;
        end
    endtask

    task automatic wait_done(input int budget, output bit to);
        int n;
        n = 0;
        to = 1'b0;
        while (!(fidx[0] == fcnt[0] && fidx[1] == fcnt[1] && !busy)) begin
            @(posedge clk);
            #2;
            n++;
            if (n > budget) begin
                to = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        total++;
        if ({gnt0, gnt1, mem_wr_en, err_badlen, busy} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000", {gnt0, gnt1, mem_wr_en, err_badlen, busy});
        end
        total++;
        if (mem_wr_addr !== 9'd0 || mem_wr_data !== 64'd0 || commited_wr_addr !== 10'd0) begin
            bad++; $display("FAIL reset_buses: got addr=%0d data=%h commit=%0d want 0", mem_wr_addr, mem_wr_data, commited_wr_addr);
        end
        do_reset();
    endtask

    task automatic test_single();
        bit to;
        do_reset();
        flen[0][0] = 8;
        build_expect(0, 0, 1, 0);
        fcnt[0] = 1;
        wait_done(300, to);
        total++;
        if (to) begin bad++; $display("FAIL single_timeout: got done=0 want 1"); end
        total++;
        if (m_gnt.size() != 1 || m_gnt[0] != 0 || both_gnt != 0) begin
            bad++; $display("FAIL single_gnt: got grants=%0d both=%0d want one grant to ch0", m_gnt.size(), both_gnt);
        end else begin
            total++;
            if (m_gcyc[0] != req_cyc[0] + 1) begin
                bad++; $display("FAIL single_gnt_lat: got cycle %0d want %0d", m_gcyc[0], req_cyc[0] + 1);
            end
        end
        total++;
        if (m_addr.size() != e_addr.size()) begin
            bad++; $display("FAIL single_nwr: got %0d want %0d", m_addr.size(), e_addr.size());
        end
        for (int k = 0; k < m_addr.size() && k < e_addr.size(); k++) begin
            total++;
            if (m_addr[k] !== 9'(e_addr[k]) || m_data[k] !== e_data[k]) begin
                bad++; $display("FAIL single_wr[%0d]: got %0d/%h want %0d/%h", k, m_addr[k], m_data[k], e_addr[k], e_data[k]);
            end
        end
        total++;
        if (m_commit.size() != 1 || m_commit[0] !== 10'd8) begin
            bad++; $display("FAIL single_commit: got n=%0d last=%0d want one commit of 8", m_commit.size(), commited_wr_addr);
        end
    endtask

    task automatic test_round_robin();
        bit to;
        do_reset();
        for (int f = 0; f < 2; f++) begin flen[0][f] = 4; flen[1][f] = 4; end
        build_expect(0, 0, 2, 2);
        fcnt[0] = 2; fcnt[1] = 2;
        wait_done(400, to);
        total++;
        if (to) begin bad++; $display("FAIL rr_timeout: got done=0 want 1"); end
        total++;
        if (m_gnt.size() != e_gnt.size() || m_commit.size() != e_commit.size() || both_gnt != 0) begin
            bad++; $display("FAIL rr_counts: got gnts=%0d commits=%0d both=%0d want 4/4/0", m_gnt.size(), m_commit.size(), both_gnt);
        end
        for (int k = 0; k < m_gnt.size() && k < e_gnt.size() && k < m_commit.size(); k++) begin
            total++;
            if (m_gnt[k] != e_gnt[k] || m_commit[k] !== 10'(e_commit[k])) begin
                bad++; $display("FAIL rr_frame[%0d]: got ch%0d commit %0d want ch%0d commit %0d", k, m_gnt[k], m_commit[k], e_gnt[k], e_commit[k]);
            end
            if (k > 0 && e_fend[k-1] < m_wcyc.size()) begin
                total++;
                if (m_gcyc[k] != m_wcyc[e_fend[k-1]] + 2) begin
                    bad++; $display("FAIL rr_gap[%0d]: got grant cycle %0d want %0d", k, m_gcyc[k], m_wcyc[e_fend[k-1]] + 2);
                end
            end
        end
        total++;
        if (m_addr.size() != e_addr.size()) begin
            bad++; $display("FAIL rr_nwr: got %0d want %0d", m_addr.size(), e_addr.size());
        end
        for (int k = 0; k < m_addr.size() && k < e_addr.size(); k++) begin
            total++;
            if (m_addr[k] !== 9'(e_addr[k]) || m_data[k] !== e_data[k]) begin
                bad++; $display("FAIL rr_wr[%0d]: got %0d/%h want %0d/%h", k, m_addr[k], m_data[k], e_addr[k], e_data[k]);
            end
        end
    endtask

    task automatic test_wrap();
        bit to;
        do_reset();
        flen[0][0] = 200; flen[0][1] = 200; flen[0][2] = 100; flen[0][3] = 20;
        fcnt[0] = 3;
        wait_done(3000, to);
        total++;
        if (to || commited_wr_addr !== 10'd500) begin
            bad++; $display("FAIL wrap_fill: got commit=%0d timeout=%0d want 500", commited_wr_addr, to);
        end
        clear_mon();
        build_expect(1, 500, 4, 0);
        fcnt[0] = 4;
        repeat (30) @(posedge clk);
        #2;
        total++;
        if (m_gnt.size() != 0 || gnt0 !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL wrap_nospace: got grants=%0d busy=%b want 0/0", m_gnt.size(), busy);
        end
        rd = 10'd8;
        wait_done(200, to);
        total++;
        if (to || m_commit.size() != 1 || commited_wr_addr !== 10'd520) begin
            bad++; $display("FAIL wrap_commit: got %0d (n=%0d) want 520", commited_wr_addr, m_commit.size());
        end
        total++;
        if (m_addr.size() != e_addr.size()) begin
            bad++; $display("FAIL wrap_nwr: got %0d want %0d", m_addr.size(), e_addr.size());
        end
        for (int k = 0; k < m_addr.size() && k < e_addr.size(); k++) begin
            total++;
            if (m_addr[k] !== 9'(e_addr[k]) || m_data[k] !== e_data[k]) begin
                bad++; $display("FAIL wrap_wr[%0d]: got %0d/%h want %0d/%h", k, m_addr[k], m_data[k], e_addr[k], e_data[k]);
            end
        end
    endtask

    task automatic test_no_starve();
        bit to;
        do_reset();
        flen[0][0] = 200; flen[0][1] = 200; flen[0][2] = 90; flen[0][3] = 2;
        flen[1][0] = 30;
        fcnt[0] = 3;
        wait_done(3000, to);
        total++;
        if (to || commited_wr_addr !== 10'd490) begin
            bad++; $display("FAIL ns_fill: got commit=%0d timeout=%0d want 490", commited_wr_addr, to);
        end
        clear_mon();
        build_expect(1, 490, 4, 1);
        fcnt[0] = 4; fcnt[1] = 1;
        repeat (40) @(posedge clk);
        #2;
        total++;
        if (m_gnt.size() != 0 || m_addr.size() != 0) begin
            bad++; $display("FAIL ns_hold: got grants=%0d writes=%0d want 0/0", m_gnt.size(), m_addr.size());
        end
        rd = 10'd20;
        wait_done(300, to);
        total++;
        if (to || m_gnt.size() != 2 || m_commit.size() != 2) begin
            bad++; $display("FAIL ns_counts: got grants=%0d commits=%0d want 2/2", m_gnt.size(), m_commit.size());
        end
        for (int k = 0; k < m_gnt.size() && k < e_gnt.size() && k < m_commit.size(); k++) begin
            total++;
            if (m_gnt[k] != e_gnt[k] || m_commit[k] !== 10'(e_commit[k])) begin
                bad++; $display("FAIL ns_frame[%0d]: got ch%0d commit %0d want ch%0d commit %0d", k, m_gnt[k], m_commit[k], e_gnt[k], e_commit[k]);
            end
        end
        for (int k = 0; k < m_addr.size() && k < e_addr.size(); k++) begin
            total++;
            if (m_addr[k] !== 9'(e_addr[k]) || m_data[k] !== e_data[k]) begin
                bad++; $display("FAIL ns_wr[%0d]: got %0d/%h want %0d/%h", k, m_addr[k], m_data[k], e_addr[k], e_data[k]);
            end
        end
    endtask

    task automatic test_badlen();
        int lens[2];
        lens[0] = 0;
        lens[1] = 201;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            total++;
            if (err_badlen !== 1'b0) begin bad++; $display("FAIL badlen_clear%0d: got %b want 0", t, err_badlen); end
            drv_en = 1'b0;
            req[0] = 1'b1;
            qw[0] = 10'(lens[t]);
            wv[0] = 1'b1;
            repeat (6) @(posedge clk);
            #2;
            total++;
            if (err_badlen !== 1'b1 || m_gnt.size() != 0 || m_addr.size() != 0 || busy !== 1'b0) begin
                bad++; $display("FAIL badlen_%0d: got err=%b grants=%0d writes=%0d want err=1 none", lens[t], err_badlen, m_gnt.size(), m_addr.size());
            end
            req[0] = 1'b0;
            wv[0] = 1'b0;
            repeat (3) @(posedge clk);
            #2;
            total++;
            if (err_badlen !== 1'b1) begin bad++; $display("FAIL badlen_sticky%0d: got %b want 1", t, err_badlen); end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int n;
        do_reset();
        flen[0][0] = 10;
        fcnt[0] = 1;
        n = 0;
        while (m_addr.size() < 3 && n < 100) begin @(negedge clk); n++; end
        total++;
        if (m_addr.size() < 3) begin bad++; $display("FAIL mid_start: got %0d writes want 3", m_addr.size()); end
        drv_en = 1'b0;
        req[0] = 1'b0;
        wv[0] = 1'b0;
        reset_n = 1'b0;
        #1;
        total++;
        if ({gnt0, gnt1, mem_wr_en, busy} !== 4'b0 || commited_wr_addr !== 10'd0 || mem_wr_addr !== 9'd0) begin
            bad++; $display("FAIL mid_reset: got flags=%b commit=%0d addr=%0d want 0", {gnt0, gnt1, mem_wr_en, busy}, commited_wr_addr, mem_wr_addr);
        end
        do_reset();
        flen[0][0] = 5;
        build_expect(0, 0, 1, 0);
        fcnt[0] = 1;
        wait_done(200, to);
        total++;
        if (to || m_commit.size() != 1 || commited_wr_addr !== 10'd5) begin
            bad++; $display("FAIL mid_commit: got %0d (n=%0d) want 5", commited_wr_addr, m_commit.size());
        end
        for (int k = 0; k < m_addr.size() && k < e_addr.size(); k++) begin
            total++;
            if (m_addr[k] !== 9'(e_addr[k]) || m_data[k] !== e_data[k]) begin
                bad++; $display("FAIL mid_wr[%0d]: got %0d/%h want %0d/%h", k, m_addr[k], m_data[k], e_addr[k], e_data[k]);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        int n0, n1;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            n0 = $urandom_range(4, 1);
            n1 = $urandom_range(4, 0);
            for (int f = 0; f < 4; f++) begin
                flen[0][f] = $urandom_range(48, 1);
                flen[1][f] = $urandom_range(48, 1);
            end
            build_expect(0, 0, n0, n1);
            fcnt[0] = n0; fcnt[1] = n1;
            wait_done(3000, to);
            total++;
            if (to || m_gnt.size() != e_gnt.size() || m_commit.size() != e_commit.size() || both_gnt != 0) begin
                bad++; $display("FAIL rand%0d_counts: got gnts=%0d commits=%0d both=%0d want %0d/%0d/0", it, m_gnt.size(), m_commit.size(), both_gnt, e_gnt.size(), e_commit.size());
            end
            for (int k = 0; k < m_gnt.size() && k < e_gnt.size() && k < m_commit.size(); k++) begin
                total++;
                if (m_gnt[k] != e_gnt[k] || m_commit[k] !== 10'(e_commit[k])) begin
                    bad++; $display("FAIL rand%0d_frame[%0d]: got ch%0d commit %0d want ch%0d commit %0d", it, k, m_gnt[k], m_commit[k], e_gnt[k], e_commit[k]);
                end
            end
            total++;
            if (m_addr.size() != e_addr.size()) begin
                bad++; $display("FAIL rand%0d_nwr: got %0d want %0d", it, m_addr.size(), e_addr.size());
            end
            for (int k = 0; k < m_addr.size() && k < e_addr.size(); k++) begin
                total++;
                if (m_addr[k] !== 9'(e_addr[k]) || m_data[k] !== e_data[k]) begin
                    bad++; $display("FAIL rand%0d_wr[%0d]: got %0d/%h want %0d/%h", it, k, m_addr[k], m_data[k], e_addr[k], e_data[k]);
                end
            end
        end
    endtask

    initial begin
        drv_en = 1'b0;
        rd = '0;
        for (int c = 0; c < 2; c++) begin
            req[c] = 1'b0; qw[c] = '0; wd[c] = '0; wv[c] = 1'b0;
            fcnt[c] = 0; fidx[c] = 0; active[c] = 1'b0; offered[c] = 1'b0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_no_starve();
        test_badlen();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
